rdy_vld_serializer: RTL and testbench

- Wide-to-narrow width converter on the team's ready/valid protocol; sits at the consuming end of a wide rdy/vld pipe.
- Accepts one wide word of up to RATIO narrow beats and replays it downstream as DWIDTH-bit beats, flagging the final beat with last_out.
- Outputs are registered, so the vld/data timing path is cut. Back-to-back words stream with zero bubble cycles.

---
 rtl/rdy_vld_serializer.sv | 105 ++++++++++
 tb/tb_rdy_vld_serializer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rdy_vld_serializer.sv
// Wide-to-narrow ready/valid serializer: one wide word of up to RATIO beats out as DWIDTH-bit beats.
// Define SER_MSB_FIRST_EN to emit the most significant valid slice first (default is LSB-first).
module rdy_vld_serializer #(
   parameter int unsigned DWIDTH = 8,
   parameter int unsigned RATIO  = 4,
   parameter int unsigned CWIDTH = $clog2(RATIO + 1)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     vld_in,
   input  logic [DWIDTH*RATIO-1:0]  din,
   input  logic [CWIDTH-1:0]        cnt_in,
   output logic                     rdy_out,
   output logic                     vld_out,
   output logic [DWIDTH-1:0]        dout,
   output logic                     last_out,
   input  logic                     rdy_in
);

   localparam int unsigned WWIDTH = DWIDTH * RATIO;
   localparam int unsigned IWIDTH = $clog2(RATIO);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_LAST = 2'd2;

   logic [1:0]        state, state_nxt;
   logic [WWIDTH-1:0] word, word_nxt;
   logic [IWIDTH-1:0] idx, idx_nxt;
   logic [CWIDTH-1:0] rem, rem_nxt;
   logic [CWIDTH-1:0] cnt_eff;
   logic [DWIDTH-1:0] dout_nxt;
   logic              accept;
   logic              xfer;

   function automatic logic [DWIDTH-1:0] slice(input logic [WWIDTH-1:0] w,
                                               input logic [IWIDTH-1:0] i);
      return DWIDTH'(w >> (32'(i) * DWIDTH));
   endfunction

   // The only combinational path: a finishing last beat frees the slot this cycle.
   assign rdy_out = ~vld_out | (rdy_in & last_out);
   assign accept  = vld_in & rdy_out;
   assign xfer    = vld_out & rdy_in;

   always_comb begin
      cnt_eff = cnt_in;
      if ((cnt_in == '0) || (cnt_in > CWIDTH'(RATIO))) begin
         cnt_eff = CWIDTH'(RATIO);
      end
   end

   always_comb begin
      state_nxt = state;
      word_nxt  = word;
      idx_nxt   = idx;
      rem_nxt   = rem;
      dout_nxt  = dout;
      if (accept) begin
         word_nxt = din;
         rem_nxt  = cnt_eff - CWIDTH'(1);
`ifdef SER_MSB_FIRST_EN
         idx_nxt  = IWIDTH'(cnt_eff - CWIDTH'(1));
`else
         idx_nxt  = '0;
`endif
         dout_nxt  = slice(din, idx_nxt);
         state_nxt = (cnt_eff == CWIDTH'(1)) ? S_LAST : S_BUSY;
      end else if (xfer) begin
         if (state == S_BUSY) begin
            rem_nxt = rem - CWIDTH'(1);
`ifdef SER_MSB_FIRST_EN
            idx_nxt = idx - IWIDTH'(1);
`else
            idx_nxt = idx + IWIDTH'(1);
`endif
            dout_nxt  = slice(word, idx_nxt);
            state_nxt = (rem_nxt == '0) ? S_LAST : S_BUSY;
         end else begin
            state_nxt = S_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         word     <= '0;
         idx      <= '0;
         rem      <= '0;
         dout     <= '0;
         vld_out  <= 1'b0;
         last_out <= 1'b0;
      end else begin
         state    <= state_nxt;
         word     <= word_nxt;
         idx      <= idx_nxt;
         rem      <= rem_nxt;
         dout     <= dout_nxt;
         vld_out  <= (state_nxt != S_IDLE);
         last_out <= (state_nxt == S_LAST);
      end
   end

endmodule

// File: tb/tb_rdy_vld_serializer.sv
// Scoreboard bench for rdy_vld_serializer (DWIDTH=8, RATIO=4); honours SER_MSB_FIRST_EN.
module tb_rdy_vld_serializer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        vld_in;
   logic [31:0] din;
   logic [2:0]  cnt_in;
   logic        rdy_out;
   logic        vld_out;
   logic [7:0]  dout;
   logic        last_out;
   logic        rdy_in;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   logic [8:0]  exp_q[$];
   int          xfer_cyc[$];

   rdy_vld_serializer #(.DWIDTH(8), .RATIO(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .vld_in   (vld_in),
      .din      (din),
      .cnt_in   (cnt_in),
      .rdy_out  (rdy_out),
      .vld_out  (vld_out),
      .dout     (dout),
      .last_out (last_out),
      .rdy_in   (rdy_in)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected beat order for a word, {last, data}
   task automatic exp_word(input logic [31:0] d, input int n);
      int ne;
      ne = (n == 0 || n > 4) ? 4 : n;
      for (int k = 0; k < ne; k++) begin
         int          s;
         logic [31:0] t;
`ifdef SER_MSB_FIRST_EN
         s = ne - 1 - k;
`else
         s = k;
`endif
         t = d >> (8 * s);
         exp_q.push_back({(k == ne - 1), t[7:0]});
      end
   endtask

   task automatic push(input logic [7:0] d, input logic l);
      exp_q.push_back({l, d});
   endtask

   // Hold the word until accepted, then scramble din/cnt_in
   task automatic send(input logic [31:0] d, input logic [2:0] c);
      bit acc;
      acc    = 0;
      vld_in = 1'b1;
      din    = d;
      cnt_in = c;
      for (int i = 0; i < 100 && !acc; i++) begin
         @(negedge clk);
         if (rdy_out) begin
            @(posedge clk);
            #1;
            acc = 1;
         end
      end
      if (!acc) chk("accept_timeout", 32'd0, 32'd1);
      vld_in = 1'b0;
      din    = $urandom;
      cnt_in = 3'($urandom);
   endtask

   task automatic drain();
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         #2;
         if (exp_q.size() == 0 && !vld_out) break;
      end
      chk("drain_left", 32'(exp_q.size()), 32'd0);
   endtask

   // Monitor: pops expected beats on transfers and checks stall stability
   logic       prev_stall = 1'b0;
   logic [7:0] prev_d;
   logic       prev_l;
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (prev_stall) begin
            chk("stall_vld", 32'(vld_out), 32'd1);
            chk("stall_data", {23'd0, last_out, dout}, {23'd0, prev_l, prev_d});
         end
         if (vld_out && rdy_in) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", {23'd0, last_out, dout}, 32'h1ff);
            end else begin
               chk("beat", {23'd0, last_out, dout}, {23'd0, exp_q.pop_front()});
            end
            xfer_cyc.push_back(cyc);
         end
         prev_stall = vld_out & ~rdy_in;
         prev_d     = dout;
         prev_l     = last_out;
      end else begin
         prev_stall = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n  = 1'b0;
      vld_in = 1'b0;
      din    = '0;
      cnt_in = '0;
      rdy_in = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_vld", 32'(vld_out), 32'd0);
      chk("rst_last", 32'(last_out), 32'd0);
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_rdy", 32'(rdy_out), 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Full word, cnt 0 means 4; rdy_out low until the last beat
      exp_word(32'h44332211, 0);
      send(32'h44332211, 3'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rdy_out_busy", 32'(rdy_out), (i == 3) ? 32'd1 : 32'd0);
      end
      drain();

      // Back-to-back words with zero bubble
      xfer_cyc.delete();
      exp_word(32'h44332211, 4);
      exp_word(32'h000000AA, 1);
      send(32'h44332211, 3'd4);
      send(32'h000000AA, 3'd1);
      drain();
      chk("b2b_beats", 32'(xfer_cyc.size()), 32'd5);
      if (xfer_cyc.size() == 5) chk("b2b_gap", 32'(xfer_cyc[4] - xfer_cyc[0]), 32'd4);

      // Backpressure: rdy_in 1,0,0,1,0,1
      exp_word(32'hDDCCBBAA, 3);
      send(32'hDDCCBBAA, 3'd3);
      foreach (exp_q[i]) begin end
      for (int i = 0; i < 6; i++) begin
         logic [5:0] pat;
         pat    = 6'b101001;
         rdy_in = pat[i];
         @(posedge clk);
         #1;
      end
      rdy_in = 1'b1;
      @(negedge clk);
      chk("bp_vld_drop", 32'(vld_out), 32'd0);
      drain();

      // Reset mid-word after the second beat
`ifdef SER_MSB_FIRST_EN
      push(8'h44, 1'b0);
      push(8'h33, 1'b0);
`else
      push(8'h11, 1'b0);
      push(8'h22, 1'b0);
`endif
      send(32'h44332211, 3'd4);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst_n  = 1'b0;
      rdy_in = 1'b0;
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      rdy_in = 1'b1;
      @(negedge clk);
      chk("mid_rst_vld", 32'(vld_out), 32'd0);
      chk("mid_rst_dout", 32'(dout), 32'd0);
      chk("mid_rst_last", 32'(last_out), 32'd0);
      chk("mid_rst_rdy", 32'(rdy_out), 32'd1);
      drain();

      // Out-of-range count treated as 4
      exp_word(32'h08070605, 7);
      send(32'h08070605, 3'd7);
      drain();

      // Partial word, cnt 3
`ifdef SER_MSB_FIRST_EN
      push(8'h33, 1'b0);
      push(8'h22, 1'b0);
      push(8'h11, 1'b1);
`else
      push(8'h11, 1'b0);
      push(8'h22, 1'b0);
      push(8'h33, 1'b1);
`endif
      send(32'h44332211, 3'd3);
      drain();

      // Single-beat words back to back with stalls between
      exp_word(32'h000000C1, 1);
      exp_word(32'h000000C2, 1);
      send(32'h000000C1, 3'd1);
      rdy_in = 1'b0;
      @(posedge clk);
      #1;
      rdy_in = 1'b1;
      send(32'h000000C2, 3'd1);
      drain();

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
